// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the pipelined ARM core.
// Owns the fetch PC, issues one-word requests to instruction memory (one
// cycle response latency), buffers returned words with their PCs in a
// DEPTH-entry FIFO and presents the head to decode as InstrF/PCF.
//
// Handshakes:
//   imem side : a request transfers when imem_req & imem_ready are both high
//               at a rising edge; imem_req/imem_addr hold until that happens.
//               The matching imem_rvalid arrives exactly one cycle later.
//   decode side: the head transfers when ValidF & ~StallF at a rising edge.
//
// Optional feature macro: FETCH_PERF_EN enables FetchCount/BubbleCount;
// when undefined both ports read 32'h0.
module fetch_stage #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        StallF,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    output logic        ValidF,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Buffer storage and bookkeeping
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q,   req_pc_d;
    logic          inflight_q, inflight_d;
    logic          drop_q,     drop_d;

    logic          pop;
    logic          accept;
    logic          resp;
    logic          push;
    logic [CW:0]   credit_use;

    // Handshake decode, credit check and outputs to decode / memory
    always_comb begin
        ValidF     = (count_q != '0);
        pop        = ValidF & ~StallF;
        // Slots already claimed once this edge retires: buffered + in-flight - popped.
        credit_use = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        imem_req   = ~reset & ~BranchTakenE & (credit_use < (CW+1)'(DEPTH));
        imem_addr  = fetch_pc_q;
        accept     = imem_req & imem_ready;
        // A response only counts if we actually have a request outstanding.
        resp       = imem_rvalid & inflight_q;
        push       = resp & ~drop_q & ~BranchTakenE;
        InstrF     = ValidF ? fifo_instr_q[rd_ptr_q] : 32'h0;
        PCF        = ValidF ? fifo_pc_q[rd_ptr_q]    : 32'h0;
        PCPlus4F   = PCF + 32'd4;
    end

    // Next-state computation for PC, pointers, count and the in-flight tracking
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = accept | (inflight_q & ~imem_rvalid);
        drop_d     = drop_q;

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            req_pc_d   = fetch_pc_q;
        end

        if (BranchTakenE) begin
            // Redirect beats any same-cycle push/pop: the buffer is emptied.
            fetch_pc_d = BranchTargetE & 32'hFFFF_FFFC;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            // Only a request whose response has not yet arrived needs dropping.
            drop_d     = inflight_q & ~imem_rvalid;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (resp && drop_q) begin
                drop_d = 1'b0;
            end
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
            req_pc_q   <= 32'h0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Buffer data write; contents are don't-care until count covers them
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= req_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q,  fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Performance counter next-state; redirect cycles count like any other
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q  + 32'(pop);
        bubble_cnt_d = bubble_cnt_q + 32'(~ValidF);
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign FetchCount  = fetch_cnt_q;
    assign BubbleCount = bubble_cnt_q;
`else
    assign FetchCount  = 32'h0;
    assign BubbleCount = 32'h0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined ARM core. It owns the fetch PC, issues word requests to instruction memory, and buffers returned words with their PCs in a small FIFO. It presents `InstrF`/`PCF` to the decode stage and the simulation monitor, and handles decode stalls and branch redirects from Execute.

## Interface
Parameters:
- `DEPTH`, 2: instruction buffer entries; power of two, ≥2.
- `RESET_PC`, 32'h0: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid; exactly one cycle after an accepted request.
- `imem_rdata`  in  32  instruction word.
- `StallF`  in  1  decode cannot take an instruction this cycle.
- `BranchTakenE`  in  1  redirect fetch.
- `BranchTargetE`  in  32  redirect address; bits [1:0] ignored.
- `ValidF`  out  1  `InstrF`/`PCF` hold a real instruction.
- `InstrF`  out  32  head instruction.
- `PCF`  out  32  address of `InstrF`.
- `PCPlus4F`  out  32  `PCF + 4`, mod 2^32.
- `FetchCount`  out  32  instructions delivered (see Configuration).
- `BubbleCount`  out  32  bubble cycles (see Configuration).

## Operation
- Internal state: `fetch_pc`, FIFO of `{pc, instr}` (`DEPTH` entries, wrapping read/write pointers, count `0..DEPTH`), `inflight` bit, `drop` bit.
- Pop: `pop = ValidF & ~StallF`. The head is consumed at the edge.
- Issue: `imem_req = ~BranchTakenE & (count + inflight - pop < DEPTH)`; `imem_addr = fetch_pc`. When the request is accepted (`imem_req & imem_ready`), `fetch_pc += 4` (wraps at 2^32), and `inflight` is set for the next cycle.
- Response: when `imem_rvalid & ~drop`, push `{pc_of_request, imem_rdata}`. `pc_of_request` is registered at accept. Push and pop in the same cycle are both performed and `count` is unchanged. The credit rule above makes overflow impossible. An `imem_rvalid` with no inflight request is ignored.
- Redirect (`BranchTakenE=1`): at the edge, flush the FIFO (`count=0`, pointers reset), set `fetch_pc = {BranchTargetE[31:2],2'b00}`, and set `drop` if a request is in flight. No request is issued in the redirect cycle. A response arriving in the redirect cycle is discarded. `drop` clears when the dropped response arrives. Redirect wins over simultaneous pop and push.
- Outputs: `ValidF = (count != 0)`. `InstrF`/`PCF` come from the FIFO head. When `ValidF=0` they read 32'h0. Outputs are stable while `StallF=1`.
- Reset: `fetch_pc=RESET_PC`, FIFO empty, `inflight=0`, `drop=0`, `ValidF=0`, `InstrF=0`, `PCF=0`, `PCPlus4F=4`, counters 0. `imem_req=0` while `reset=1`. Reset mid-flight discards any pending response.

## Timing
- Fetch latency: request in cycle N, `imem_rvalid` in N+1, `ValidF` high from N+2.
- First instruction after reset release (cycle 0, `imem_ready=1`): `ValidF=1`, `PCF=RESET_PC` in cycle 2.
- Sustained throughput: 1 instr/cycle with `imem_ready=1` and `StallF=0`.
- Redirect penalty: `BranchTakenE` in cycle N gives a request to the target in N+1, target `ValidF` in N+3, and `ValidF=0` in N+1..N+2.
- `imem_ready=0` holds `imem_req`/`imem_addr` stable until accepted.

## Configuration
- `FETCH_PERF_EN` defined: `FetchCount` increments on each `pop`. `BubbleCount` increments on each non-reset cycle with `ValidF=0`. Both wrap at 2^32, clear on reset, and on a redirect cycle count normally.
- Undefined: both counters are removed and the ports are tied to 32'h0.

## Test plan
- Reset release, memory at 0 = e04f000f, 4 = e2801032, `StallF=0` -> cycle 2 `PCF=0`, `InstrF=e04f000f`; cycle 3 `PCF=4`, `InstrF=e2801032`, `PCPlus4F=8`.
- `StallF=1` for 3 cycles with head at PC 8 -> `PCF` stays 8, `count` saturates at `DEPTH`, `imem_req` deasserts, no instruction lost or duplicated after release.
- `BranchTakenE` with `BranchTargetE=32'h0C` while a request to 0x14 is in flight -> the 0x14 word is dropped, `ValidF=0` for 2 cycles, next `PCF=0x0C`.
- `imem_ready` low for 2 cycles -> `imem_addr` held, `ValidF` gap of 2 cycles, addresses remain contiguous.
- Assert `reset` mid-stream with `inflight=1` -> next cycle `ValidF=0`, fetch restarts at `RESET_PC`, and the stale response is not pushed.
- With `FETCH_PERF_EN`, 10 cycles after reset release with no stalls -> `FetchCount=8`, `BubbleCount=2`. Without the macro both read 0.
